// File: rtl/stat_pipe.sv
// Y86 pipeline status tracker: carries per-instruction status from fetch to writeback,
// merges the data-memory error at the memory stage, and commits a sticky CPU status.
module stat_pipe #(
    parameter int STAGES    = 5,
    parameter int MEM_STAGE = 3,
    parameter int CNT_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [3:0]            icode_i,
    input  logic                  instr_valid_i,
    input  logic                  imem_error_i,
    input  logic                  dmem_error_i,
    input  logic [STAGES-1:0]     stall_i,
    input  logic [STAGES-1:0]     bubble_i,
    output logic [2*STAGES-1:0]   stage_stat_o,
    output logic [1:0]            stat_o,
    output logic                  halted_o,
    output logic                  mem_suppress_o,
    output logic [CNT_W-1:0]      cycle_cnt_o,
    output logic [CNT_W-1:0]      retire_cnt_o
);

    localparam int WB = STAGES - 1;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    logic              r_valid [1:STAGES-1];
    stat_e             r_stat  [1:STAGES-1];
    stat_e             r_cpu_stat;
    logic              r_halted;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic              w_valid [0:STAGES-1];
    stat_e             w_eff   [0:STAGES-1];
    logic [2*STAGES-1:0] w_stage_stat;
    logic              w_mem_suppress;
    logic              w_unused;

    // Stage 0 never has a register of its own, so its control bits are don't-cares.
    assign w_unused = ^{stall_i[0], bubble_i[0]};

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_valid[0] = 1'b1;
        if (imem_error_i)
            w_eff[0] = STAT_ADR;
        else if (!instr_valid_i)
            w_eff[0] = STAT_INS;
        else if (icode_i == 4'h1)
            w_eff[0] = STAT_HLT;
        else
            w_eff[0] = STAT_AOK;

        for (int k = 1; k < STAGES; k++) begin
            w_valid[k] = r_valid[k];
            w_eff[k]   = r_valid[k] ? r_stat[k] : STAT_AOK;
            // A data-memory fault only shows on an instruction that is still clean.
            if (k == MEM_STAGE && r_valid[k] && r_stat[k] == STAT_AOK && dmem_error_i)
                w_eff[k] = STAT_ADR;
        end
    end

    always_comb begin
        w_stage_stat   = '0;
        w_mem_suppress = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_stage_stat[2*k +: 2] = w_eff[k];
            if (k >= MEM_STAGE && w_valid[k] && w_eff[k] != STAT_AOK)
                w_mem_suppress = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every stage samples its neighbour's old value.
    // NOTE: the small stage arrays are reset because valid gates commit and retire counting.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_stat[k]  <= STAT_AOK;
            end
        end else if (!r_halted) begin
            for (int k = 1; k < STAGES; k++) begin
                if (bubble_i[k]) begin
                    r_valid[k] <= 1'b0;
                    r_stat[k]  <= STAT_AOK;
                end else if (!stall_i[k]) begin
                    r_valid[k] <= w_valid[k-1];
                    r_stat[k]  <= w_eff[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cpu_stat   <= STAT_AOK;
            r_halted     <= 1'b0;
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else if (!r_halted) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (r_valid[WB]) begin
                if (w_eff[WB] != STAT_AOK) begin
                    r_cpu_stat <= w_eff[WB];
                    r_halted   <= 1'b1;
                end
                // HLT completes normally; ADR/INS are faults and never retire.
                if (w_eff[WB] == STAT_AOK || w_eff[WB] == STAT_HLT)
                    r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign stage_stat_o   = w_stage_stat;
    assign stat_o         = r_cpu_stat;
    assign halted_o       = r_halted;
    assign mem_suppress_o = w_mem_suppress;
    assign cycle_cnt_o    = r_cycle_cnt;
    assign retire_cnt_o   = r_retire_cnt;

endmodule

// File: tb/tb_stat_pipe.sv
// Bench for stat_pipe: directed scenarios with hand-computed values plus a randomized run
// compared every cycle against an instruction-level status model.
module tb_stat_pipe;

    localparam int S = 5;
    localparam int M = 3;
    localparam int W = S - 1;

    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b1;
    logic [3:0]   icode_i = 4'h0;
    logic         instr_valid_i = 1'b1;
    logic         imem_error_i = 1'b0;
    logic         dmem_error_i = 1'b0;
    logic [S-1:0] stall_i = '0;
    logic [S-1:0] bubble_i = '0;

    logic [2*S-1:0] stage_stat_o, stage_stat_w4;
    logic [1:0]     stat_o, stat_w4;
    logic           halted_o, halted_w4;
    logic           mem_suppress_o, mem_suppress_w4;
    logic [31:0]    cycle_cnt_o, retire_cnt_o;
    logic [3:0]     cycle_cnt_w4, retire_cnt_w4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    stat_pipe #(.STAGES(S), .MEM_STAGE(M), .CNT_W(32)) u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .icode_i(icode_i), .instr_valid_i(instr_valid_i),
        .imem_error_i(imem_error_i), .dmem_error_i(dmem_error_i), .stall_i(stall_i),
        .bubble_i(bubble_i), .stage_stat_o(stage_stat_o), .stat_o(stat_o),
        .halted_o(halted_o), .mem_suppress_o(mem_suppress_o), .cycle_cnt_o(cycle_cnt_o),
        .retire_cnt_o(retire_cnt_o)
    );

    stat_pipe #(.STAGES(S), .MEM_STAGE(M), .CNT_W(4)) u_dut_w4 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .icode_i(icode_i), .instr_valid_i(instr_valid_i),
        .imem_error_i(imem_error_i), .dmem_error_i(dmem_error_i), .stall_i(stall_i),
        .bubble_i(bubble_i), .stage_stat_o(stage_stat_w4), .stat_o(stat_w4),
        .halted_o(halted_w4), .mem_suppress_o(mem_suppress_w4), .cycle_cnt_o(cycle_cnt_w4),
        .retire_cnt_o(retire_cnt_w4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       v;
        logic [1:0] st;
    } slot_t;

    slot_t       m_pipe [S];
    logic [1:0]  m_stat;
    logic        m_halted;
    logic [31:0] m_cycle, m_retire;

    function automatic logic [1:0] fetch_stat();
        if (imem_error_i)   return 2'd2;
        if (!instr_valid_i) return 2'd3;
        if (icode_i == 4'h1) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [1:0] m_eff(int k);
        if (k == 0) return fetch_stat();
        if (!m_pipe[k].v) return 2'd0;
        if (k == M && m_pipe[k].st == 2'd0 && dmem_error_i) return 2'd2;
        return m_pipe[k].st;
    endfunction

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < S; k++) m_pipe[k] <= '0;
            m_stat   <= 2'd0;
            m_halted <= 1'b0;
            m_cycle  <= '0;
            m_retire <= '0;
        end else if (!m_halted) begin
            m_cycle <= m_cycle + 1;
            for (int k = 1; k < S; k++) begin
                if (bubble_i[k])
                    m_pipe[k] <= '0;
                else if (!stall_i[k])
                    m_pipe[k] <= {(k == 1) ? 1'b1 : m_pipe[k-1].v, m_eff(k-1)};
            end
            if (m_pipe[W].v) begin
                if (m_eff(W) != 2'd0) begin
                    m_stat   <= m_eff(W);
                    m_halted <= 1'b1;
                end
                if (m_eff(W) <= 2'd1) m_retire <= m_retire + 1;
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            logic [2*S-1:0] exp_ss;
            logic           exp_ms;
            exp_ms = 1'b0;
            for (int k = 0; k < S; k++) begin
                exp_ss[2*k +: 2] = m_eff(k);
                if (k >= M && (k == 0 || m_pipe[k].v) && m_eff(k) != 2'd0) exp_ms = 1'b1;
            end
            check("stage_stat",    64'(stage_stat_o),   64'(exp_ss));
            check("stat",          64'(stat_o),         64'(m_stat));
            check("halted",        64'(halted_o),       64'(m_halted));
            check("mem_suppress",  64'(mem_suppress_o), 64'(exp_ms));
            check("cycle_cnt",     64'(cycle_cnt_o),    64'(m_cycle));
            check("retire_cnt",    64'(retire_cnt_o),   64'(m_retire));
            check("cycle_cnt_w4",  64'(cycle_cnt_w4),   64'(m_cycle[3:0]));
            check("retire_cnt_w4", 64'(retire_cnt_w4),  64'(m_retire[3:0]));
            check("stat_w4",       64'(stat_w4),        64'(m_stat));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        icode_i       = 4'h0;
        instr_valid_i = 1'b1;
        imem_error_i  = 1'b0;
        dmem_error_i  = 1'b0;
        stall_i       = '0;
        bubble_i      = '0;
    endtask

    // Asserts reset between edges and checks that it clears everything without a clock.
    task automatic do_reset();
        rst_n_i = 1'b0;
        idle_inputs();
        #1;
        check("rst_stat",       64'(stat_o),         64'd0);
        check("rst_halted",     64'(halted_o),       64'd0);
        check("rst_cycle",      64'(cycle_cnt_o),    64'd0);
        check("rst_retire",     64'(retire_cnt_o),   64'd0);
        check("rst_cycle_w4",   64'(cycle_cnt_w4),   64'd0);
        check("rst_stage_stat", 64'(stage_stat_o),   64'd0);
        check("rst_mem_supp",   64'(mem_suppress_o), 64'd0);
        tick();
        tick();
        rst_n_i = 1'b1;
    endtask

    task automatic random_inputs();
        int r;
        r = $urandom_range(0, 99);
        icode_i       = (r < 3) ? 4'h1 : (r < 50) ? 4'h0 : 4'($urandom_range(2, 15));
        instr_valid_i = ($urandom_range(0, 99) >= 2);
        imem_error_i  = ($urandom_range(0, 99) < 2);
        dmem_error_i  = ($urandom_range(0, 99) < 8);
        for (int b = 0; b < S; b++) begin
            stall_i[b]  = ($urandom_range(0, 99) < 12);
            bubble_i[b] = ($urandom_range(0, 99) < 6);
        end
    endtask

    initial begin
        #2;

        // Four AOK instructions then HLT: halts after edge 9 with 5 retired.
        do_reset();
        for (int t = 0; t < 13; t++) begin
            icode_i = (t < 4) ? 4'h3 : 4'h1;
            tick();
            if (t + 1 == 8) check("s1_not_yet_halted", 64'(halted_o), 64'd0);
            if (t + 1 == 9 || t + 1 == 13) begin
                check("s1_halted", 64'(halted_o),     64'd1);
                check("s1_stat",   64'(stat_o),       64'd1);
                check("s1_retire", 64'(retire_cnt_o), 64'd5);
                check("s1_cycle",  64'(cycle_cnt_o),  64'd9);
            end
        end

        // Instruction-memory error at fetch becomes ADR and never retires.
        do_reset();
        imem_error_i  = 1'b1;
        instr_valid_i = 1'b0;
        tick();
        idle_inputs();
        check("s2_stage1_adr", 64'(stage_stat_o[3:2]), 64'd2);
        for (int e = 2; e <= 5; e++) begin
            tick();
            if (e == 4) check("s2_not_yet_halted", 64'(halted_o), 64'd0);
        end
        check("s2_stat",   64'(stat_o),       64'd2);
        check("s2_retire", 64'(retire_cnt_o), 64'd0);

        // INS in the memory stage is not overridden by a data-memory error.
        do_reset();
        instr_valid_i = 1'b0;
        tick();
        idle_inputs();
        tick();
        tick();
        dmem_error_i = 1'b1;
        #1;
        check("s3_ins_kept",     64'(stage_stat_o[7:6]), 64'd3);
        check("s3_ins_suppress", 64'(mem_suppress_o),    64'd1);
        tick();
        dmem_error_i = 1'b0;
        tick();
        check("s3_ins_stat", 64'(stat_o), 64'd3);

        // A clean instruction in the memory stage with a data-memory error becomes ADR.
        do_reset();
        tick();
        tick();
        tick();
        check("s3_clean_supp", 64'(mem_suppress_o), 64'd0);
        dmem_error_i = 1'b1;
        #1;
        check("s3_adr",      64'(stage_stat_o[7:6]), 64'd2);
        check("s3_suppress", 64'(mem_suppress_o),    64'd1);
        tick();
        dmem_error_i = 1'b0;
        tick();
        check("s3_adr_stat",   64'(stat_o),       64'd2);
        check("s3_adr_retire", 64'(retire_cnt_o), 64'd0);

        // Stage 2 stalls while stage 3 bubbles for two cycles: HLT commit moves from edge 5 to 7.
        do_reset();
        icode_i = 4'h1;
        tick();
        icode_i = 4'h0;
        tick();
        stall_i[2]  = 1'b1;
        bubble_i[3] = 1'b1;
        for (int e = 3; e <= 4; e++) begin
            tick();
            check("s4_stage2_held",   64'(stage_stat_o[5:4]), 64'd1);
            check("s4_stage3_bubble", 64'(stage_stat_o[7:6]), 64'd0);
        end
        idle_inputs();
        tick();
        check("s4_delayed", 64'(halted_o), 64'd0);
        tick();
        tick();
        check("s4_halted", 64'(halted_o),     64'd1);
        check("s4_stat",   64'(stat_o),       64'd1);
        check("s4_retire", 64'(retire_cnt_o), 64'd1);

        // Bubble beats stall on stage 1.
        do_reset();
        icode_i = 4'h1;
        tick();
        stall_i[1]  = 1'b1;
        bubble_i[1] = 1'b1;
        tick();
        idle_inputs();
        check("s5_bubble_wins", 64'(stage_stat_o[3:2]), 64'd0);
        check("s5_next_stage",  64'(stage_stat_o[5:4]), 64'd1);
        for (int e = 3; e <= 8; e++) tick();

        // Twenty AOK cycles: the 4-bit counter wraps 15 -> 0 and reads 4.
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 15) check("s6_w4_at15", 64'(cycle_cnt_w4), 64'd15);
            if (e == 16) check("s6_w4_wrap", 64'(cycle_cnt_w4), 64'd0);
        end
        check("s6_w4_cycle", 64'(cycle_cnt_w4), 64'd4);
        check("s6_cycle",    64'(cycle_cnt_o),  64'd20);
        check("s6_retire",   64'(retire_cnt_o), 64'd16);

        // Randomized episodes; do_reset here also exercises reset in the middle of a run.
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                random_inputs();
                tick();
            end
        end

        idle_inputs();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
